// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the popcount_window block.
package popcount_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StAccum
   } win_state_e;

   function automatic int unsigned acc_width(input int unsigned downto,
                                             input int unsigned win_w);
      return downto + win_w;
   endfunction

endpackage

// File: rtl/popcount_half.sv
// Combinational population count of a W-bit slice, result in CW bits.
module popcount_half #(
   parameter int unsigned W  = 8,
   parameter int unsigned CW = 4
) (
   input  logic [W-1:0]  data_i,
   output logic [CW-1:0] count_o
);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < W; i++) begin
         count_o = count_o + CW'(data_i[i]);
      end
   end

endmodule

// File: rtl/popcount_window.sv
// Two-stage popcount pipeline feeding a windowed accumulator (IDLE/ACCUM FSM).
// Optional running-peak output enabled by defining POPCOUNT_PEAK_EN.
module popcount_window
   import popcount_pkg::*;
#(
   parameter int unsigned FROM   = 16,
   parameter int unsigned DOWNTO = 5,
   parameter int unsigned WIN_W  = 8,
   localparam int unsigned ACC_W = acc_width(DOWNTO, WIN_W)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic [FROM-1:0]   bin,
   input  logic [WIN_W-1:0]  win_len,
   output logic              cnt_valid,
   output logic [DOWNTO-1:0] cnt,
   output logic              sum_valid,
   output logic [ACC_W-1:0]  sum
`ifdef POPCOUNT_PEAK_EN
   ,
   output logic [DOWNTO-1:0] peak
`endif
);

   localparam int unsigned LoW = (FROM + 1) / 2;
   localparam int unsigned HiW = FROM / 2;

   if (FROM < 1 || FROM > 64) begin : g_bad_from
      $error("popcount_window: FROM must be in 1..64");
   end
   if ((64'd1 << DOWNTO) <= 64'(FROM)) begin : g_bad_downto
      $error("popcount_window: 2^DOWNTO must exceed FROM");
   end

   // Stage 1: split popcount
   logic [DOWNTO-1:0] lo_cnt, hi_cnt;

   popcount_half #(
      .W  (LoW),
      .CW (DOWNTO)
   ) u_lo (
      .data_i  (bin[LoW-1:0]),
      .count_o (lo_cnt)
   );

   if (HiW > 0) begin : g_hi
      popcount_half #(
         .W  (HiW),
         .CW (DOWNTO)
      ) u_hi (
         .data_i  (bin[FROM-1:LoW]),
         .count_o (hi_cnt)
      );
   end else begin : g_no_hi
      assign hi_cnt = '0;
   end

   logic [DOWNTO-1:0] lo_cnt_q, hi_cnt_q;
   logic              s1_valid_q;
   logic [DOWNTO-1:0] cnt_q, cnt_d;
   logic              cnt_valid_q;

   assign cnt_d = lo_cnt_q + hi_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lo_cnt_q    <= '0;
         hi_cnt_q    <= '0;
         s1_valid_q  <= 1'b0;
         cnt_q       <= '0;
         cnt_valid_q <= 1'b0;
      end else begin
         lo_cnt_q    <= lo_cnt;
         hi_cnt_q    <= hi_cnt;
         s1_valid_q  <= in_valid;
         cnt_q       <= cnt_d;
         cnt_valid_q <= s1_valid_q;
      end
   end

   // Window accumulator
   win_state_e        state_q, state_d;
   logic [WIN_W-1:0]  len_q, len_d;
   logic [WIN_W-1:0]  n_q, n_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  sum_q, sum_d;
   logic              sum_valid_q, sum_valid_d;
   logic              close;
`ifdef POPCOUNT_PEAK_EN
   logic [DOWNTO-1:0] max_q, max_d;
   logic [DOWNTO-1:0] peak_q, peak_d;
`endif

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      n_d         = n_q;
      acc_d       = acc_q;
      sum_d       = sum_q;
      sum_valid_d = 1'b0;
      close       = 1'b0;
`ifdef POPCOUNT_PEAK_EN
      max_d       = max_q;
      peak_d      = peak_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (cnt_valid_q) begin
               // A zero length is treated as single-sample windows
               len_d = (win_len == '0) ? WIN_W'(1) : win_len;
               n_d   = WIN_W'(1);
               acc_d = ACC_W'(cnt_q);
`ifdef POPCOUNT_PEAK_EN
               max_d = cnt_q;
`endif
               if (len_d == WIN_W'(1)) begin
                  close = 1'b1;
               end else begin
                  state_d = StAccum;
               end
            end
         end
         StAccum: begin
            if (cnt_valid_q) begin
               acc_d = acc_q + ACC_W'(cnt_q);
               n_d   = n_q + WIN_W'(1);
`ifdef POPCOUNT_PEAK_EN
               if (cnt_q > max_q) max_d = cnt_q;
`endif
               if (n_d == len_q) begin
                  close   = 1'b1;
                  state_d = StIdle;
               end
            end
         end
      endcase
      if (close) begin
         sum_d       = acc_d;
         sum_valid_d = 1'b1;
`ifdef POPCOUNT_PEAK_EN
         peak_d      = max_d;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         len_q       <= '0;
         n_q         <= '0;
         acc_q       <= '0;
         sum_q       <= '0;
         sum_valid_q <= 1'b0;
`ifdef POPCOUNT_PEAK_EN
         max_q       <= '0;
         peak_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         n_q         <= n_d;
         acc_q       <= acc_d;
         sum_q       <= sum_d;
         sum_valid_q <= sum_valid_d;
`ifdef POPCOUNT_PEAK_EN
         max_q       <= max_d;
         peak_q      <= peak_d;
`endif
      end
   end

   assign cnt_valid = cnt_valid_q;
   assign cnt       = cnt_q;
   assign sum_valid = sum_valid_q;
   assign sum       = sum_q;
`ifdef POPCOUNT_PEAK_EN
   assign peak      = peak_q;
`endif

endmodule

// File: tb/tb_popcount_window.sv
// Self-checking bench for popcount_window: vector table, directed corner
// sequences and random traffic, all checked through cycle-stamped scoreboards.
module tb_popcount_window;

   localparam int unsigned FROM   = 16;
   localparam int unsigned DOWNTO = 5;
   localparam int unsigned WIN_W  = 8;
   localparam int unsigned ACC_W  = DOWNTO + WIN_W;

   logic              clk      = 1'b0;
   logic              reset_n  = 1'b1;
   logic              in_valid = 1'b0;
   logic [FROM-1:0]   bin      = '0;
   logic [WIN_W-1:0]  win_len  = '0;
   logic              cnt_valid;
   logic [DOWNTO-1:0] cnt;
   logic              sum_valid;
   logic [ACC_W-1:0]  sum;
`ifdef POPCOUNT_PEAK_EN
   logic [DOWNTO-1:0] peak;
`endif

   popcount_window #(
      .FROM   (FROM),
      .DOWNTO (DOWNTO),
      .WIN_W  (WIN_W)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .bin       (bin),
      .win_len   (win_len),
      .cnt_valid (cnt_valid),
      .cnt       (cnt),
      .sum_valid (sum_valid),
      .sum       (sum)
`ifdef POPCOUNT_PEAK_EN
      ,
      .peak      (peak)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int unsigned val;
      int unsigned pk;
      int          cyc;
   } exp_t;

   exp_t cnt_exp[$];
   exp_t sum_exp[$];
   exp_t e_mon;
   int unsigned last_sum = 0;

   // Reference window model, advanced as samples are driven
   bit          m_open = 1'b0;
   int unsigned m_len, m_n, m_acc, m_max;

   task automatic model_sample(input int unsigned c);
      cnt_exp.push_back('{c, 0, cyc + 2});
      if (!m_open) begin
         m_len = (win_len == 0) ? 1 : int'(win_len);
         m_acc = c;
         m_max = c;
         m_n   = 1;
         if (m_len == 1) sum_exp.push_back('{m_acc, m_max, cyc + 3});
         else m_open = 1'b1;
      end else begin
         m_acc += c;
         if (c > m_max) m_max = c;
         m_n++;
         if (m_n == m_len) begin
            sum_exp.push_back('{m_acc, m_max, cyc + 3});
            m_open = 1'b0;
         end
      end
   endtask

   task automatic drive(input logic v, input logic [FROM-1:0] b, input int unsigned c);
      in_valid = v;
      bin      = b;
      if (v) model_sample(c);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, '0, 0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset_n  = 1'b0;
      cnt_exp.delete();
      sum_exp.delete();
      m_open   = 1'b0;
      last_sum = 0;
      #2;
      check("reset_cnt_valid", cnt_valid, 0);
      check("reset_cnt", cnt, 0);
      check("reset_sum_valid", sum_valid, 0);
      check("reset_sum", sum, 0);
`ifdef POPCOUNT_PEAK_EN
      check("reset_peak", peak, 0);
`endif
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         while (cnt_exp.size() > 0 && cnt_exp[0].cyc < cyc) begin
            check("cnt_missing_at_cycle", cyc, cnt_exp[0].cyc);
            void'(cnt_exp.pop_front());
         end
         while (sum_exp.size() > 0 && sum_exp[0].cyc < cyc) begin
            check("sum_missing_at_cycle", cyc, sum_exp[0].cyc);
            void'(sum_exp.pop_front());
         end
         if (cnt_valid) begin
            if (cnt_exp.size() == 0) begin
               check("cnt_valid_unexpected", cnt_valid, 0);
            end else begin
               e_mon = cnt_exp.pop_front();
               check("cnt_cycle", cyc, e_mon.cyc);
               check("cnt_value", cnt, e_mon.val);
            end
         end
         if (sum_valid) begin
            if (sum_exp.size() == 0) begin
               check("sum_valid_unexpected", sum_valid, 0);
            end else begin
               e_mon = sum_exp.pop_front();
               last_sum = e_mon.val;
               check("sum_cycle", cyc, e_mon.cyc);
               check("sum_value", sum, e_mon.val);
`ifdef POPCOUNT_PEAK_EN
               check("peak_value", peak, e_mon.pk);
`endif
            end
         end else begin
            check("sum_hold", sum, last_sum);
         end
      end
   end

   typedef struct {
      logic [FROM-1:0]  bin;
      logic [WIN_W-1:0] wl;
      int               gap;
      int unsigned      exp_cnt;
   } vec_t;

   vec_t tbl[10];

   initial begin
      logic [FROM-1:0] rb;
      logic            rv;

      tbl[0] = '{16'h007F, 8'd4, 0, 7};
      tbl[1] = '{16'h0AAA, 8'd4, 0, 6};
      tbl[2] = '{16'h08E4, 8'd4, 0, 5};
      tbl[3] = '{16'h0920, 8'd4, 3, 3};
      tbl[4] = '{16'hFFFF, 8'd0, 0, 16};
      tbl[5] = '{16'hFFFF, 8'd0, 0, 16};
      tbl[6] = '{16'hFFFF, 8'd0, 3, 16};
      tbl[7] = '{16'h0001, 8'd3, 2, 1};
      tbl[8] = '{16'h0001, 8'd3, 2, 1};
      tbl[9] = '{16'h0001, 8'd3, 3, 1};

      #1;
      do_reset();
      idle(2);

      for (int i = 0; i < 10; i++) begin
         win_len = tbl[i].wl;
         drive(1'b1, tbl[i].bin, tbl[i].exp_cnt);
         idle(tbl[i].gap);
      end
      idle(2);

      // Reset in the middle of an open window
      win_len = 8'd4;
      drive(1'b1, 16'h000F, 4);
      drive(1'b1, 16'h000F, 4);
      do_reset();
      idle(1);
      for (int i = 0; i < 4; i++) drive(1'b1, 16'h000F, 4);
      idle(5);
      check("reset_window_sum", sum, 16);

      // Length change while the window is open
      win_len = 8'd2;
      drive(1'b1, 16'h0003, 2);
      idle(2);
      win_len = 8'd5;
      drive(1'b1, 16'h0001, 1);
      for (int i = 0; i < 5; i++) drive(1'b1, 16'h0007, 3);
      idle(5);
      check("len5_window_sum", sum, 15);

      // Longest window with all-ones input
      win_len = 8'd255;
      for (int i = 0; i < 255; i++) drive(1'b1, 16'hFFFF, 16);
      idle(5);
      check("max_window_sum", sum, 4080);

      for (int s = 0; s < 2; s++) begin
         win_len = (s == 0) ? 8'd3 : 8'd7;
         repeat (40) begin
            rv = ($urandom_range(0, 9) < 7);
            rb = FROM'($urandom);
            drive(rv, rb, $countones(rb));
         end
         while (m_open) drive(1'b1, 16'hFFFF, 16);
         idle(4);
      end

      idle(6);
      check("cnt_queue_drained", cnt_exp.size(), 0);
      check("sum_queue_drained", sum_exp.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
